move_undo_stack: RTL
====================

// Module: move_undo_stack
// PURPOSE
//  Tracks a 2-D position (x,y) stepped by +/-STEP per move and records each accepted move on a LIFO.
//  An undo request pops the last move and applies its inverse, restoring the prior position.
//  Sits beside the path-search datapath's step ALU: forward moves go in, reverse moves come out for backtracking.
// PARAMETERS
//  SIZE   5   coordinate width (unsigned); arithmetic width is SIZE+1 with sign in bit SIZE
//  STEP   5   magnitude of one move
//  DEPTH  16  stack entries (power of two); pointer width $clog2(DEPTH)+1
// PORTS
//  clk      in   1     single clock, rising edge
//  rst      in   1     asynchronous, active-high reset
//  clr      in   1     synchronous clear: sp=0, x=y=0, state IDLE
//  ld       in   1     load x_ld/y_ld into x/y; stack untouched
//  x_ld     in   SIZE  load value for x
//  y_ld     in   SIZE  load value for y
//  push     in   1     apply forward move push_dir and record it
//  push_dir in   2     00 x+STEP, 01 x-STEP, 10 y+STEP, 11 y-STEP
//  undo     in   1     pop last move and apply its inverse
//  x,y      out  SIZE  current position
//  busy     out  1     undo sequence in progress
//  done     out  1     1-cycle pulse when an undo completes
//  err      out  1     1-cycle pulse on rejected push/undo or out-of-range result
//  empty    out  1     sp==0
//  full     out  1     sp==DEPTH
// BEHAVIOUR
//  Reset/clr: x=y=0, sp=0, busy=done=err=0, empty=1, full=0, state IDLE; rst takes effect at once, mid-sequence included.
//  Arithmetic: res = {1'b0,coord} +/- STEP in SIZE+1 bits; res[SIZE]=1 means out of range.
//   The result is rejected (err pulse, coord unchanged) when it is negative or > 2^SIZE-1.
//  Priority in IDLE: clr > ld > push > undo; a lower-priority request in the same cycle is dropped silently.
//  push (IDLE only, 1-cycle latency):
//   - full: err, nothing changes.
//   - out of range: err, not recorded.
//   - otherwise coord updates and push_dir is stored at stack[sp], sp++.
//  undo FSM:
//   - IDLE -> POP on undo: if empty, err pulse and stay IDLE.
//   - POP: read stack[sp-1], sp--, busy=1.
//   - APPLY: apply inverse of popped dir. If the inverse is out of range (possible after ld), err pulse, coord unchanged, entry stays popped.
//   - DONE: done=1 for one cycle -> IDLE.
//   - Latency undo -> done: 3 cycles. busy=1 in POP/APPLY/DONE.
//  push/ld/undo are ignored while busy; clr is honoured in any state.
//  empty/full are combinational from sp.
// CONFIGURATION
//  UNDO_ALL_EN defined: adds input undo_all.
//   - In IDLE with !empty it loops POP/APPLY until sp==0, then one done pulse.
//   - err pulses per failed step; the loop continues.
//   - Priority: just below undo.
//  Undefined: no undo_all port, single-step undo only.
// STRUCTURE
//  Package move_pkg:
//   - dir_t (2-bit encodings above)
//   - state_t {IDLE,POP,APPLY,DONE}
//   - function inv_dir (flips bit 0)
//  Sub-module step_alu (combinational): in1, in2, sel_y, sub -> res[SIZE:0], sign.
//   - One instance, shared by push and APPLY.
//  Stack is a flat register array; no RAM macro.
// TESTING (SIZE=5, STEP=5, DEPTH=4)
//  1. ld x=10,y=0; push 00 -> x=15 next cycle, empty=0; undo -> done 3 cycles later, x=10, empty=1.
//  2. x=0; push 01 -> err=1 one cycle, x=0, empty=1. x=30; push 00 -> err, x=30.
//  3. Four pushes 10 from y=0 -> y=20, full=1; fifth push -> err, y=20, full=1.
//  4. undo with empty=1 -> err pulse, busy stays 0, done stays 0.
//  5. push 00 then undo; assert rst during APPLY -> x=y=0, busy=0, empty=1 immediately.
//  6. UNDO_ALL_EN: from (0,0) push 00,10,00 -> (10,5); undo_all -> single done pulse, (0,0), empty=1.

Source files
------------

// File: rtl/move_undo_stack_pkg.sv
// Shared types for the move/undo stack: move encodings, undo FSM states
// and the helper that turns a move into its inverse.
package move_pkg;

  typedef enum logic [1:0] {
    X_PLUS  = 2'b00,
    X_MINUS = 2'b01,
    Y_PLUS  = 2'b10,
    Y_MINUS = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    POP   = 2'b01,
    APPLY = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Bit 0 selects the sign of the step, so flipping it reverses the move.
  function automatic dir_t inv_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/move_undo_stack_step_alu.sv
// Combinational step adder shared by forward pushes and undo application.
// res[SIZE] set means the stepped coordinate left the 0..2^SIZE-1 range.
module step_alu #(
  parameter int SIZE = 5,
  parameter int STEP = 5
) (
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  input  logic            sel_y,
  input  logic            sub,
  output logic [SIZE:0]   res,
  output logic            sign
);

  logic [SIZE:0] operand;

  // Unsigned coordinate widened by one bit so both underflow and overflow land in res[SIZE].
  always_comb begin
    if (sel_y) begin
      operand = {1'b0, in2};
    end else begin
      operand = {1'b0, in1};
    end
    if (sub) begin
      res = operand - (SIZE+1)'(STEP);
    end else begin
      res = operand + (SIZE+1)'(STEP);
    end
    sign = sub & res[SIZE];
  end

endmodule

// File: rtl/move_undo_stack.sv
// 2-D position tracker with a LIFO of accepted moves and an undo FSM.
// Optional build macro UNDO_ALL_EN adds an undo_all input that unwinds the whole stack.
module move_undo_stack
  import move_pkg::*;
#(
  parameter int SIZE  = 5,
  parameter int STEP  = 5,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            ld,
  input  logic [SIZE-1:0] x_ld,
  input  logic [SIZE-1:0] y_ld,
  input  logic            push,
  input  logic [1:0]      push_dir,
  input  logic            undo,
`ifdef UNDO_ALL_EN
  input  logic            undo_all,
`endif
  output logic [SIZE-1:0] x,
  output logic [SIZE-1:0] y,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_dec;
  dir_t          stack [DEPTH];
  dir_t          pop_dir;
  dir_t          alu_dir;
  logic          all_mode;
  logic          all_req;
  logic [SIZE:0] alu_res;
  logic          alu_sign;
  logic          bad;
  logic          push_ok;

`ifdef UNDO_ALL_EN
  assign all_req = undo_all;
`else
  assign all_req = 1'b0;
`endif

  assign empty  = (sp == PW'(0));
  assign full   = (sp == PW'(DEPTH));
  assign sp_dec = sp - PW'(1);

  // The single ALU sees the forward move in IDLE and the inverse of the popped move otherwise.
  always_comb begin
    if (state == IDLE) begin
      alu_dir = dir_t'(push_dir);
    end else begin
      alu_dir = inv_dir(pop_dir);
    end
  end

  step_alu #(.SIZE(SIZE), .STEP(STEP)) u_alu (
    .in1   (x),
    .in2   (y),
    .sel_y (alu_dir[1]),
    .sub   (alu_dir[0]),
    .res   (alu_res),
    .sign  (alu_sign)
  );

  assign bad     = alu_res[SIZE] | alu_sign;
  assign push_ok = (state == IDLE) && !clr && !ld && push && !full && !bad;

  // Move history storage; no reset needed since sp guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack[sp[PW-2:0]] <= dir_t'(push_dir);
    end
  end

  // Position, stack pointer and undo sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sp       <= PW'(0);
      x        <= SIZE'(0);
      y        <= SIZE'(0);
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      all_mode <= 1'b0;
      pop_dir  <= X_PLUS;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        sp       <= PW'(0);
        x        <= SIZE'(0);
        y        <= SIZE'(0);
        busy     <= 1'b0;
        all_mode <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ld) begin
              x <= x_ld;
              y <= y_ld;
            end else if (push) begin
              if (push_ok) begin
                if (alu_dir[1]) y <= alu_res[SIZE-1:0];
                else            x <= alu_res[SIZE-1:0];
                sp <= sp + PW'(1);
              end else begin
                err <= 1'b1;
              end
            end else if (undo) begin
              if (empty) begin
                err <= 1'b1;
              end else begin
                state    <= POP;
                busy     <= 1'b1;
                all_mode <= 1'b0;
              end
            end else if (all_req && !empty) begin
              state    <= POP;
              busy     <= 1'b1;
              all_mode <= 1'b1;
            end
          end
          POP: begin
            pop_dir <= stack[sp_dec[PW-2:0]];
            sp      <= sp_dec;
            state   <= APPLY;
          end
          APPLY: begin
            // A failed inverse still consumes the entry.
            if (bad) begin
              err <= 1'b1;
            end else if (alu_dir[1]) begin
              y <= alu_res[SIZE-1:0];
            end else begin
              x <= alu_res[SIZE-1:0];
            end
            if (all_mode && !empty) begin
              state <= POP;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            all_mode <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
